// File: rtl/blink_pattern_seq.sv
// LED pattern sequencer: steps chase/bounce/fill/blink-all frames on each blink tick
// for a commanded number of sweeps (0 = run until abort).
module blink_pattern_seq #(
  parameter int unsigned NLED  = 8,
  parameter int unsigned RBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_pattern,
  input  logic [RBITS-1:0] cmd_reps,
  input  logic             abort,
  output logic [NLED-1:0]  leds,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SBITS = $clog2(2 * NLED);
  localparam int unsigned TW    = NLED + 1;

  localparam logic [1:0] PAT_CHASE  = 2'd0;
  localparam logic [1:0] PAT_BOUNCE = 2'd1;
  localparam logic [1:0] PAT_FILL   = 2'd2;
  localparam logic [1:0] PAT_BLINK  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       pat_q, pat_d;
  logic [RBITS-1:0] reps_q, reps_d;
  logic [RBITS-1:0] sweep_q, sweep_d, sweep_inc;
  logic [SBITS-1:0] step_q, step_d;
  logic [NLED-1:0]  leds_d;
  logic             busy_d, done_d;

  // Last step index of one sweep for each pattern.
  function automatic logic [SBITS-1:0] last_step(input logic [1:0] pat);
    logic [SBITS-1:0] p;
    p = SBITS'(1);
    case (pat)
      PAT_CHASE:  p = SBITS'(NLED - 1);
      PAT_BOUNCE: p = SBITS'(2 * NLED - 3);
      PAT_FILL:   p = SBITS'(NLED);
      default:    p = SBITS'(1);
    endcase
    return p;
  endfunction

  // Frame shown at a given step position within a sweep.
  function automatic logic [NLED-1:0] frame_of(input logic [1:0] pat,
                                               input logic [SBITS-1:0] pos);
    logic [NLED-1:0] f;
    logic [TW-1:0]   therm;
    f     = '0;
    therm = (TW'(1) << pos) - TW'(1);
    case (pat)
      PAT_CHASE: f = NLED'(1) << pos;
      PAT_BOUNCE: begin
        if (pos < SBITS'(NLED)) f = NLED'(1) << pos;
        else                    f = NLED'(1) << (SBITS'(2 * NLED - 2) - pos);
      end
      PAT_FILL:  f = therm[NLED-1:0];
      default:   f = pos[0] ? '0 : '1;
    endcase
    return f;
  endfunction

  assign cmd_ready = (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      reps_q  <= '0;
      sweep_q <= '0;
      step_q  <= '0;
      leds    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      reps_q  <= reps_d;
      sweep_q <= sweep_d;
      step_q  <= step_d;
      leds    <= leds_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    reps_d    = reps_q;
    sweep_d   = sweep_q;
    step_d    = step_q;
    leds_d    = leds;
    busy_d    = busy;
    done_d    = 1'b0;
    sweep_inc = sweep_q + RBITS'(1);

    case (state_q)
      S_IDLE: begin
        leds_d = '0;
        busy_d = 1'b0;
        if (cmd_valid) begin
          pat_d   = cmd_pattern;
          reps_d  = cmd_reps;
          sweep_d = '0;
          step_d  = '0;
          state_d = S_ARM;
          busy_d  = 1'b1;
          leds_d  = frame_of(cmd_pattern, '0);
        end
      end
      S_ARM: begin
        if (abort) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          leds_d  = '0;
        end else if (tick) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          leds_d  = '0;
        end else if (tick) begin
          if (step_q == last_step(pat_q)) begin
            // End of sweep: either finish or restart from the first frame.
            if (reps_q != '0 && sweep_inc == reps_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              leds_d  = '0;
            end else begin
              sweep_d = sweep_inc;
              step_d  = '0;
              leds_d  = frame_of(pat_q, '0);
            end
          end else begin
            step_d = step_q + SBITS'(1);
            leds_d = frame_of(pat_q, step_q + SBITS'(1));
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        leds_d  = '0;
      end
    endcase
  end

endmodule
